// File: rtl/mistable_pkg.sv
// rtl/mistable_pkg.sv - shared scheduler state type and coordinate width
package mistable_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mistable_frame_sched_if.sv
// rtl/mistable_frame_sched_if.sv - coordinate beat stream between scheduler and pixel sink
interface mistable_frame_sched_if;
  import mistable_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               sof;
  logic               eol;
  logic               eof;

  modport master (
    output out_valid, pix_x, pix_y, sof, eol, eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, pix_x, pix_y, sof, eol, eof,
    output out_ready
  );

endinterface

// File: rtl/mistable_raster_cnt.sv
// rtl/mistable_raster_cnt.sv - x/y raster position counter with line/frame end flags
module mistable_raster_cnt
  import mistable_pkg::*;
#(
  parameter int W = 256,
  parameter int H = 240
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_x,
  output logic               last_xy
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(H - 1);

  assign last_x  = (x == X_LAST);
  assign last_xy = last_x && (y == Y_LAST);

  // Step across the line, wrap to the next line, and wrap to (0,0) after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (last_x) begin
        x <= '0;
        y <= last_xy ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mistable_frame_sched.sv
// rtl/mistable_frame_sched.sv - raster frame scheduler; MISTABLE_SCHED_BLANK_EN adds line/frame blanking
module mistable_frame_sched
  import mistable_pkg::*;
#(
  parameter int W = 256,
  parameter int H = 240
`ifdef MISTABLE_SCHED_BLANK_EN
  ,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_start,
  input  logic                          cmd_single,
  input  logic                          cmd_stop,
  mistable_frame_sched_if.master        stream,
  output logic                          busy,
  output logic                          frame_done,
  output logic [COORD_W-1:0]            frame_cnt
);

  sched_state_t       state_q;
  sched_state_t       state_d;
  logic               continuous_q;
  logic               continuous_d;
  logic               beat;
  logic               cnt_clr;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               last_x;
  logic               last_xy;
  logic               frame_done_q;
  logic [15:0]        frame_cnt_q;
`ifdef MISTABLE_SCHED_BLANK_EN
  logic [15:0]        blank_q;
  logic [15:0]        blank_d;
`endif

  assign beat = (state_q == ST_ACTIVE) && stream.out_ready;

  mistable_raster_cnt #(
    .W(W),
    .H(H)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .adv     (beat),
    .x       (x),
    .y       (y),
    .last_x  (last_x),
    .last_xy (last_xy)
  );

  // Next-state logic; the command decode feeds the frame-end decision in the same cycle.
  always_comb begin
    state_d      = state_q;
    continuous_d = continuous_q;
    cnt_clr      = 1'b0;
`ifdef MISTABLE_SCHED_BLANK_EN
    blank_d      = blank_q;
`endif
    if (cmd_stop || cmd_single) begin
      continuous_d = 1'b0;
    end else if (cmd_start) begin
      continuous_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!cmd_stop && (cmd_single || cmd_start)) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (beat && last_xy) begin
`ifdef MISTABLE_SCHED_BLANK_EN
          state_d = ST_VBLANK;
          blank_d = 16'(VBLANK - 1);
`else
          state_d = continuous_d ? ST_ACTIVE : ST_IDLE;
`endif
        end
`ifdef MISTABLE_SCHED_BLANK_EN
        else if (beat && last_x) begin
          state_d = ST_HBLANK;
          blank_d = 16'(HBLANK - 1);
        end
`endif
      end
`ifdef MISTABLE_SCHED_BLANK_EN
      ST_HBLANK: begin
        if (blank_q == 16'd0) begin
          state_d = ST_ACTIVE;
        end else begin
          blank_d = blank_q - 16'd1;
        end
      end
      ST_VBLANK: begin
        if (blank_q == 16'd0) begin
          state_d = continuous_d ? ST_ACTIVE : ST_IDLE;
        end else begin
          blank_d = blank_q - 16'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      continuous_q <= 1'b0;
`ifdef MISTABLE_SCHED_BLANK_EN
      blank_q      <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      continuous_q <= continuous_d;
`ifdef MISTABLE_SCHED_BLANK_EN
      blank_q      <= blank_d;
`endif
    end
  end

  // Completed-frame count and the registered done pulse following the eof beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      frame_done_q <= beat && last_xy;
      if (beat && last_xy) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign stream.out_valid = (state_q == ST_ACTIVE);
  assign stream.pix_x     = x;
  assign stream.pix_y     = y;
  assign stream.sof       = stream.out_valid && (x == '0) && (y == '0);
  assign stream.eol       = stream.out_valid && last_x;
  assign stream.eof       = stream.out_valid && last_xy;
  assign busy             = (state_q != ST_IDLE);
  assign frame_done       = frame_done_q;
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_mistable_frame_sched.sv
// tb/tb_mistable_frame_sched.sv - scoreboard bench for the raster frame scheduler
module tb_mistable_frame_sched;
  import mistable_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int VB = 3;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        cmd_start  = 1'b0;
  logic        cmd_single = 1'b0;
  logic        cmd_stop   = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  mistable_frame_sched_if sif ();

  mistable_frame_sched #(
    .W(W),
    .H(H)
`ifdef MISTABLE_SCHED_BLANK_EN
    ,
    .HBLANK(HB),
    .VBLANK(VB)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_start  (cmd_start),
    .cmd_single (cmd_single),
    .cmd_stop   (cmd_stop),
    .stream     (sif),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];

  function automatic beat_t observe();
    beat_t b;
    b.x   = sif.pix_x;
    b.y   = sif.pix_y;
    b.sof = sif.sof;
    b.eol = sif.eol;
    b.eof = sif.eof;
    return b;
  endfunction

  task automatic push_frame();
    beat_t b;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        b.x   = 16'(xx);
        b.y   = 16'(yy);
        b.sof = (xx == 0) && (yy == 0);
        b.eol = (xx == W - 1);
        b.eof = (xx == W - 1) && (yy == H - 1);
        sb.push_back(b);
      end
    end
  endtask

  // Advance to the next falling edge, drop command pulses, and set ready for the coming edge.
  task automatic tick(input logic rdy);
    @(negedge clk);
    cmd_start     = 1'b0;
    cmd_single    = 1'b0;
    cmd_stop      = 1'b0;
    sif.out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    tick(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({sif.out_valid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl: got valid/busy/done=%b%b%b required 000", sif.out_valid, busy, frame_done);
    end
    total++;
    if ({sif.pix_x, sif.pix_y, frame_cnt} !== 48'd0) begin
      bad++;
      $display("FAIL reset_regs: got x=%0d y=%0d cnt=%0d required 0 0 0", sif.pix_x, sif.pix_y, frame_cnt);
    end
    total++;
    if ({sif.sof, sif.eol, sif.eof} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b%b%b required 000", sif.sof, sif.eol, sif.eof);
    end
  endtask

  task automatic test_single();
    beat_t got, exp;
    int    beats = 0;
    int    dones = 0;
    logic  prev_eof = 1'b0;
    do_reset();
    push_frame();
    cmd_single = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick(1'b1);
      if (c == 0) begin
        total++;
        if (sif.out_valid !== 1'b1) begin
          bad++;
          $display("FAIL start_latency: got valid=%b required 1", sif.out_valid);
        end
      end
      total++;
      if (frame_done !== prev_eof) begin
        bad++;
        $display("FAIL frame_done_timing: cycle %0d got %b required %b", c, frame_done, prev_eof);
      end
      if (frame_done) dones++;
      prev_eof = sif.out_valid && sif.out_ready && sif.eof;
      if (sif.out_valid && sif.out_ready) begin
        got = observe();
        beats++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got beat (%0d,%0d) required none", got.x, got.y);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL beat: got (%0d,%0d) sle=%b%b%b required (%0d,%0d) sle=%b%b%b",
                     got.x, got.y, got.sof, got.eol, got.eof, exp.x, exp.y, exp.sof, exp.eol, exp.eof);
          end
        end
      end
    end
    total++;
    if (beats != W * H || dones != 1) begin
      bad++;
      $display("FAIL single_counts: got beats=%0d dones=%0d required %0d 1", beats, dones, W * H);
    end
    total++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0 || sif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_end: got cnt=%0d busy=%b valid=%b required 1 0 0", frame_cnt, busy, sif.out_valid);
    end
  endtask

  task automatic test_continuous();
    beat_t got, exp;
    int    beats = 0;
    logic  prev_eof = 1'b0;
    do_reset();
    push_frame();
    push_frame();
    cmd_start = 1'b1;
    for (int c = 0; c < 150; c++) begin
      tick(1'b1);
`ifndef MISTABLE_SCHED_BLANK_EN
      if (prev_eof && beats == W * H) begin
        total++;
        if (!(sif.out_valid === 1'b1 && sif.pix_x === 16'd0 && sif.pix_y === 16'd0)) begin
          bad++;
          $display("FAIL frame_gap: got valid=%b (%0d,%0d) required 1 (0,0)", sif.out_valid, sif.pix_x, sif.pix_y);
        end
      end
`endif
      prev_eof = sif.out_valid && sif.out_ready && sif.eof;
      if (sif.out_valid && sif.out_ready) begin
        got = observe();
        beats++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got beat (%0d,%0d) required none", got.x, got.y);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL beat: got (%0d,%0d) sle=%b%b%b required (%0d,%0d) sle=%b%b%b",
                     got.x, got.y, got.sof, got.eol, got.eof, exp.x, exp.y, exp.sof, exp.eol, exp.eof);
          end
        end
        if (beats == W * H + 10) cmd_stop = 1'b1;
      end
    end
    total++;
    if (beats != 2 * W * H || frame_cnt !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_stop: got beats=%0d cnt=%0d busy=%b required %0d 2 0", beats, frame_cnt, busy, 2 * W * H);
    end
  endtask

  task automatic test_backpressure();
    beat_t got, exp, held;
    int    beats   = 0;
    logic  stalled = 1'b0;
    do_reset();
    push_frame();
    push_frame();
    cmd_start = 1'b1;
    for (int c = 0; c < 500; c++) begin
      tick(1'($urandom_range(0, 1)));
      got = observe();
      if (stalled) begin
        total++;
        if (sif.out_valid !== 1'b1 || got !== held) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b (%0d,%0d) required 1 (%0d,%0d)",
                   sif.out_valid, got.x, got.y, held.x, held.y);
        end
      end
      stalled = sif.out_valid && !sif.out_ready;
      held    = got;
      if (sif.out_valid && sif.out_ready) begin
        beats++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got beat (%0d,%0d) required none", got.x, got.y);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL beat: got (%0d,%0d) sle=%b%b%b required (%0d,%0d) sle=%b%b%b",
                     got.x, got.y, got.sof, got.eol, got.eof, exp.x, exp.y, exp.sof, exp.eol, exp.eof);
          end
        end
        if (beats == W * H + 8) cmd_stop = 1'b1;
      end
    end
    total++;
    if (beats != 2 * W * H || frame_cnt !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_counts: got beats=%0d cnt=%0d busy=%b required %0d 2 0", beats, frame_cnt, busy, 2 * W * H);
    end
  endtask

`ifdef MISTABLE_SCHED_BLANK_EN
  task automatic test_blanking();
    logic exp_v[60];
    int   idx = 0;
    for (int i = 0; i < 60; i++) exp_v[i] = 1'b0;
    for (int l = 0; l < H; l++) begin
      for (int i = 0; i < W; i++) begin
        exp_v[idx] = 1'b1;
        idx++;
      end
      idx += (l < H - 1) ? HB : VB;
    end
    do_reset();
    cmd_single = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick(1'($urandom_range(0, 1)));
      total++;
      if (sif.out_valid !== exp_v[c] || busy !== (c < idx)) begin
        bad++;
        $display("FAIL blank_timing: cycle %0d got valid=%b busy=%b required %b %b",
                 c, sif.out_valid, busy, exp_v[c], (c < idx));
      end
      sif.out_ready = 1'b1;
    end
    total++;
    if (idx != 41 || frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL blank_frame: got len=%0d cnt=%0d required 41 1", idx, frame_cnt);
    end
  endtask
`endif

  task automatic test_async_reset();
    beat_t got, exp;
    logic  found = 1'b0;
    do_reset();
    push_frame();
    cmd_single = 1'b1;
    for (int c = 0; c < 60; c++) tick(1'b1);
    sb.delete();
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ar_pre_cnt: got %0d required 1", frame_cnt);
    end
    push_frame();
    cmd_single = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      tick(1'b1);
      got = observe();
      if (sif.out_valid && got.x == 16'd3 && got.y == 16'd2) begin
        found = 1'b1;
      end else if (sif.out_valid) begin
        total++;
        exp = sb.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL beat: got (%0d,%0d) required (%0d,%0d)", got.x, got.y, exp.x, exp.y);
        end
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL ar_reach: got no beat (3,2) required one");
    end
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    total++;
    if ({sif.out_valid, busy, frame_done, sif.sof, sif.eol, sif.eof} !== 6'd0) begin
      bad++;
      $display("FAIL ar_ctrl: got v/b/d/s/l/e=%b%b%b%b%b%b required 000000",
               sif.out_valid, busy, frame_done, sif.sof, sif.eol, sif.eof);
    end
    total++;
    if ({sif.pix_x, sif.pix_y, frame_cnt} !== 48'd0) begin
      bad++;
      $display("FAIL ar_regs: got x=%0d y=%0d cnt=%0d required 0 0 0", sif.pix_x, sif.pix_y, frame_cnt);
    end
    tick(1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1'b1);
      total++;
      if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL ar_idle: cycle %0d got valid=%b busy=%b required 0 0", c, sif.out_valid, busy);
      end
    end
  endtask

  task automatic test_commands();
    beat_t got, exp;
    int    beats = 0;
    do_reset();
    cmd_start = 1'b1;
    cmd_stop  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1'b1);
      total++;
      if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL start_stop_idle: cycle %0d got valid=%b busy=%b required 0 0", c, sif.out_valid, busy);
      end
    end
    push_frame();
    push_frame();
    cmd_start = 1'b1;
    for (int c = 0; c < 150; c++) begin
      tick(1'b1);
      if (sif.out_valid && sif.out_ready) begin
        got = observe();
        beats++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got beat (%0d,%0d) required none", got.x, got.y);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL beat: got (%0d,%0d) sle=%b%b%b required (%0d,%0d) sle=%b%b%b",
                     got.x, got.y, got.sof, got.eol, got.eof, exp.x, exp.y, exp.sof, exp.eol, exp.eof);
          end
        end
        if (got.eof && beats == 2 * W * H) cmd_stop = 1'b1;
      end
    end
    total++;
    if (beats != 2 * W * H || frame_cnt !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_on_eof: got beats=%0d cnt=%0d busy=%b required %0d 2 0", beats, frame_cnt, busy, 2 * W * H);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt;
    do_reset();
    force dut.frame_cnt_q = 16'hFFFE;
    tick(1'b1);
    release dut.frame_cnt_q;
    tick(1'b1);
    for (int f = 0; f < 2; f++) begin
      exp_cnt = (f == 0) ? 16'hFFFF : 16'h0000;
      cmd_single = 1'b1;
      for (int c = 0; c < 60; c++) tick(1'b1);
      total++;
      if (frame_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL cnt_wrap: frame %0d got %h required %h", f, frame_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    sif.out_ready = 1'b0;
    test_reset();
    test_single();
    test_continuous();
    test_backpressure();
`ifdef MISTABLE_SCHED_BLANK_EN
    test_blanking();
`endif
    test_async_reset();
    test_commands();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mistable_frame_sched.md
# mistable_frame_sched

Raster scheduler that sequences frame generation for the test-pattern pixel datapath. It issues pixel coordinates under a valid/ready handshake so downstream sinks can apply backpressure. It also runs frames continuously or one at a time under start/stop/single commands and counts completed frames. It sits between the host control registers and the colour-bar generator; the generator's colour logic consumes `pix_x`/`pix_y` combinationally.

## Interface
- `W`, 256: active pixels per line (≥2)
- `H`, 240: active lines per frame (≥2)
- `HBLANK`, 16: idle cycles after each line (≥1; used only with blanking compiled in)
- `VBLANK`, 64: idle cycles after each frame (≥1; used only with blanking compiled in)

Ports:
- `clk` input 1: clock
- `rst_n` input 1: reset, asynchronous, active-low
- `cmd_start` input 1: single-cycle pulse; begin continuous frames
- `cmd_single` input 1: single-cycle pulse; run exactly one frame
- `cmd_stop` input 1: single-cycle pulse; finish current frame, then idle
- `out_valid` output 1: coordinate beat valid
- `out_ready` input 1: sink accepts beat
- `pix_x` output 16: current column
- `pix_y` output 16: current row
- `sof` output 1: beat is (0,0)
- `eol` output 1: beat is column W-1
- `eof` output 1: beat is (W-1,H-1)
- `busy` output 1: state ≠ IDLE
- `frame_done` output 1: one-cycle pulse per completed frame
- `frame_cnt` output 16: completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK. HBLANK and VBLANK exist only with blanking compiled in.
- Beat = cycle with `out_valid && out_ready`. `pix_x`, `pix_y`, `sof`, `eol` and `eof` are held stable while `out_valid && !out_ready`.
- `out_valid` = 1 exactly when state is ACTIVE.
- `sof`, `eol` and `eof` are decoded from the registered coordinates and are valid only with `out_valid`.
- `continuous` flag: set by `cmd_start`, cleared by `cmd_single` or `cmd_stop`.

IDLE:
- `cmd_start` → ACTIVE at (0,0) with `continuous` = 1.
- `cmd_single` → ACTIVE at (0,0) with `continuous` = 0.
- Precedence when several commands arrive in the same cycle: `cmd_stop` > `cmd_single` > `cmd_start`. A lone `cmd_stop` in IDLE is a no-op.

ACTIVE:
- On a beat that is not `eol`, increment x.
- On an `eol` beat that is not `eof`: x←0, y←y+1. With blanking, go to HBLANK.
- On an `eof` beat: x←0, y←0, `frame_cnt`+1, and `frame_done` pulses in the next cycle.
  - Without blanking: stay ACTIVE if `continuous`, else go to IDLE.
  - With blanking: go to VBLANK.
- `cmd_start` while busy sets `continuous` and does not restart the frame.
- `cmd_single` or `cmd_stop` while busy clears `continuous`; the current frame completes.
- A command arriving on the same cycle as the `eof` beat takes effect for that frame-end decision.

HBLANK and VBLANK:
- A 16-bit down-counter is loaded with HBLANK-1 or VBLANK-1 on entry. Exit when it reaches 0.
- HBLANK → ACTIVE.
- VBLANK → ACTIVE if `continuous`, else IDLE.

## Timing
Reset values:
- State IDLE, `continuous` 0.
- `pix_x` 0, `pix_y` 0, `frame_cnt` 0.
- `out_valid` 0, `frame_done` 0, `busy` 0.
- `sof`, `eol` and `eof` are decoded; they are 0 because `out_valid` is 0.

Latency and throughput:
- Command in cycle N → `out_valid` = 1 with (0,0) in cycle N+1.
- Throughput is one beat per cycle while `out_ready` = 1. Without blanking there is no bubble between lines or between continuous frames.
- With blanking:
  - `out_valid` = 0 for exactly HBLANK cycles after each non-final line.
  - `out_valid` = 0 for exactly VBLANK cycles after each frame.
  - Blank counters run regardless of `out_ready`.

Counters and pulses:
- `frame_cnt` updates on the edge ending the `eof` beat.
- `frame_done` is registered: high for one cycle, one cycle after the `eof` beat.

Asynchronous reset:
- Assertion of `rst_n` mid-frame immediately clears all state to reset values.
- The next frame requires a fresh command.

## Configuration
- `MISTABLE_SCHED_BLANK_EN` defined:
  - HBLANK and VBLANK states, the blank counter and the HBLANK/VBLANK parameters are in effect.
- `MISTABLE_SCHED_BLANK_EN` undefined:
  - Those states, the counter and the parameters are absent.
  - Transitions run straight through as described in Operation.

## Structure
Shared package `mistable_pkg` holds:
- `sched_state_t` enum (IDLE, ACTIVE, HBLANK, VBLANK)
- `COORD_W` = 16

Sub-module `mistable_raster_cnt`:
- x/y counter with `adv` enable, W/H parameters, synchronous `clr`.
- Outputs `last_x` and `last_xy`.
- The scheduler FSM drives `adv` with the beat signal.

## Test plan
All scenarios use W=8, H=4, HBLANK=2, VBLANK=3.
1. Reset, then pulse `cmd_single` with `out_ready`=1.
   - Exactly 32 beats, (0,0)…(7,3).
   - `sof` only on the first beat, `eol` on x=7, `eof` on (7,3).
   - `frame_done` pulses once, `frame_cnt`=1, then IDLE with `out_valid`=0.
2. Pulse `cmd_start`, hold `out_ready`=1 with blanking off.
   - Frames run back-to-back with no gaps: after (7,3), (0,0) appears in the next cycle.
   - `cmd_stop` mid-frame 2 → frame 2 completes, `frame_cnt`=2, then IDLE.
3. Random `out_ready` (50%).
   - Coordinates are held stable across every stall.
   - Sequence is gap-free and in order, with 32 beats per frame.
4. Blanking on, `cmd_single`.
   - `out_valid` low for exactly 2 cycles after lines 0, 1 and 2.
   - Low for 3 cycles after (7,3), then IDLE.
   - Total frame time 32+6+3 = 41 cycles.
5. Assert `rst_n`=0 asynchronously at beat (3,2).
   - All outputs are 0 immediately.
   - After release, no beats occur until a new command.
6. Same-cycle commands.
   - `cmd_start` + `cmd_stop` in IDLE → stays IDLE.
   - `cmd_stop` on the `eof` beat during continuous run → IDLE after that frame.
   - `frame_cnt` preset near wrap via 65536 frames (or force) shows 0xFFFF→0.
